// File: rtl/free_list_if.sv
// Dispatch / retire / rollback bus between the ROB-side control and the
// physical-register free list. The core side drives through master; the free
// list itself attaches through slave.
interface free_list_if #(
  parameter int NUM_PR   = 64,
  parameter int NUM_ARCH = 32,
  parameter int NUM_ROB  = 32
);
  localparam int TW = $clog2(NUM_PR);
  localparam int RW = $clog2(NUM_ROB);
  localparam int CW = $clog2(NUM_PR - NUM_ARCH) + 1;

  logic                 en;
  logic                 dispatch_en;
  logic [1:0][RW-1:0]   dispatch_ROB_idx;
  logic [1:0]           retire_en;
  logic [1:0][TW-1:0]   retire_Told_idx;
  logic                 rollback_en;
  logic [RW-1:0]        rollback_ROB_idx;
  logic [1:0][TW-1:0]   T_idx;
  logic                 FL_valid;
  logic [CW-1:0]        free_count;

  modport master (
    output en, dispatch_en, dispatch_ROB_idx, retire_en, retire_Told_idx,
           rollback_en, rollback_ROB_idx,
    input  T_idx, FL_valid, free_count
  );

  modport slave (
    input  en, dispatch_en, dispatch_ROB_idx, retire_en, retire_Told_idx,
           rollback_en, rollback_ROB_idx,
    output T_idx, FL_valid, free_count
  );
endinterface

// File: rtl/free_list.sv
// 2-wide physical-register free list: circular buffer of free tags with a
// wrap-bit head/tail, plus a per-ROB-entry snapshot of head for rollback.
// Optional macro FL_BYPASS_EN lets retiring tags feed same-cycle dispatch
// when the buffer holds fewer than two tags.
module free_list #(
  parameter int NUM_PR    = 64,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_ROB   = 32,
  parameter int NUM_SUPER = 2
) (
  input  logic      clock,
  input  logic      reset,
  free_list_if.slave bus
);
  localparam int FL_SIZE = NUM_PR - NUM_ARCH;
  localparam int IW      = $clog2(FL_SIZE);
  localparam int PW      = IW + 1;
  localparam int TW      = $clog2(NUM_PR);

  logic [TW-1:0] r_fl   [FL_SIZE];
  logic [PW-1:0] r_snap [NUM_ROB];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;

  logic [PW-1:0]                 w_count;
  logic [PW-1:0]                 w_head1;
  logic [PW-1:0]                 w_tail1;
  logic [1:0]                    w_push_cnt;
  logic [1:0]                    w_pop_n;
  logic [1:0]                    w_byp_n;
  logic [1:0]                    w_byp_eff;
  logic                          w_fl_valid;
  logic                          w_dispatch;
  logic                          w_rollback;
  logic [PW-1:0]                 w_head_next;
  logic [PW-1:0]                 w_tail_next;
  logic [NUM_SUPER-1:0]          w_wr_en;
  logic [NUM_SUPER-1:0][IW-1:0]  w_wr_idx;
  logic [NUM_SUPER-1:0][TW-1:0]  w_wr_data;

  assign w_count    = r_tail - r_head;
  assign w_head1    = r_head + PW'(1);
  assign w_tail1    = r_tail + PW'(1);
  assign w_push_cnt = 2'(bus.retire_en[0]) + 2'(bus.retire_en[1]);

  // Offered tags, dispatch legality and how many tags come out of the buffer.
  always_comb begin
    bus.T_idx[0] = r_fl[r_head[IW-1:0]];
    bus.T_idx[1] = r_fl[w_head1[IW-1:0]];
    w_pop_n      = 2'd2;
    w_byp_n      = 2'd0;
`ifdef FL_BYPASS_EN
    w_fl_valid   = (({1'b0, w_count} + (PW+1)'(w_push_cnt)) >= (PW+1)'(2))
                   & ~bus.rollback_en;
    if (w_count == PW'(0)) begin
      bus.T_idx[0] = bus.retire_Told_idx[0];
      bus.T_idx[1] = bus.retire_Told_idx[1];
      w_pop_n      = 2'd0;
      w_byp_n      = 2'd2;
    end else if (w_count == PW'(1)) begin
      bus.T_idx[1] = bus.retire_Told_idx[0];
      w_pop_n      = 2'd1;
      w_byp_n      = 2'd1;
    end
`else
    w_fl_valid   = (w_count >= PW'(2)) & ~bus.rollback_en;
`endif
  end

  assign bus.FL_valid   = w_fl_valid;
  assign bus.free_count = w_count;
  assign w_dispatch     = bus.en & bus.dispatch_en & w_fl_valid;
  assign w_rollback     = bus.en & bus.rollback_en;
  assign w_byp_eff      = w_dispatch ? w_byp_n : 2'd0;

  // Retired tags that were not bypassed are packed into consecutive tail slots.
  always_comb begin
    w_wr_en      = '0;
    w_wr_idx[0]  = r_tail[IW-1:0];
    w_wr_idx[1]  = w_tail1[IW-1:0];
    w_wr_data[0] = bus.retire_Told_idx[0];
    w_wr_data[1] = bus.retire_Told_idx[1];
    if (w_byp_eff == 2'd0) begin
      w_wr_en = {bus.en & bus.retire_en[1], bus.en & bus.retire_en[0]};
    end else if (w_byp_eff == 2'd1) begin
      w_wr_en[0]   = bus.en & bus.retire_en[1];
      w_wr_data[0] = bus.retire_Told_idx[1];
    end
  end

  // Pointer next-state: rollback overrides dispatch, retire always advances tail.
  always_comb begin
    w_head_next = r_head;
    w_tail_next = r_tail;
    if (bus.en) begin
      w_tail_next = r_tail + PW'(w_push_cnt) - PW'(w_byp_eff);
      if (w_rollback) begin
        w_head_next = r_snap[bus.rollback_ROB_idx];
      end else if (w_dispatch) begin
        w_head_next = r_head + PW'(w_pop_n);
      end
    end
  end

  // Head/tail registers; reset leaves the buffer full (tail has wrap bit set).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= PW'(FL_SIZE);
    end else begin
      r_head <= w_head_next;
      r_tail <= w_tail_next;
    end
  end

  // Tag storage: reset image holds every non-architectural tag, retire pushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        r_fl[i] <= TW'(NUM_ARCH + i);
      end
    end else begin
      if (w_wr_en[0]) r_fl[w_wr_idx[0]] <= w_wr_data[0];
      if (w_wr_en[1]) r_fl[w_wr_idx[1]] <= w_wr_data[1];
    end
  end

  // Snapshot of pre-increment head per dispatched ROB slot, for rollback.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROB; i++) begin
        r_snap[i] <= '0;
      end
    end else if (w_dispatch) begin
      r_snap[bus.dispatch_ROB_idx[0]] <= r_head;
      r_snap[bus.dispatch_ROB_idx[1]] <= w_head1;
    end
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the buffer; a violation means a push while full.
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    (w_tail_next - w_head_next) <= PW'(FL_SIZE));
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed, table-driven bench for free_list: each vector drives one cycle of
// inputs, checks the combinational outputs against the current state, then
// clocks. Hand sequences cover reset image and (with FL_BYPASS_EN) bypass.
module tb_free_list;
  localparam int TW = 6;
  localparam int RW = 5;

  typedef struct {
    int rst; int en; int disp; int rob0; int rob1; int ret;
    int told0; int told1; int rb; int rbidx; int nb;
    int e_t0; int e_t1; int e_valid; int e_cnt;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;
  vec_t vecs[$];

  free_list_if #(.NUM_PR(64), .NUM_ARCH(32), .NUM_ROB(32)) bus ();

  free_list #(.NUM_PR(64), .NUM_ARCH(32), .NUM_ROB(32), .NUM_SUPER(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(int rst, int en, int disp, int rob0, int rob1,
                              int ret, int told0, int told1, int rb, int rbidx,
                              int nb, int e_t0, int e_t1, int e_valid, int e_cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.disp = disp; v.rob0 = rob0; v.rob1 = rob1;
    v.ret = ret; v.told0 = told0; v.told1 = told1; v.rb = rb; v.rbidx = rbidx;
    v.nb = nb; v.e_t0 = e_t0; v.e_t1 = e_t1; v.e_valid = e_valid; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset                   = v.rst[0];
    bus.en                  = v.en[0];
    bus.dispatch_en         = v.disp[0];
    bus.dispatch_ROB_idx[0] = RW'(v.rob0);
    bus.dispatch_ROB_idx[1] = RW'(v.rob1);
    bus.retire_en           = 2'(v.ret);
    bus.retire_Told_idx[0]  = TW'(v.told0);
    bus.retire_Told_idx[1]  = TW'(v.told1);
    bus.rollback_en         = v.rb[0];
    bus.rollback_ROB_idx    = RW'(v.rbidx);
  endtask

  initial begin
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Drain from full with 16 double dispatches.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 1, 1, 2*k, 2*k+1, 0, 0, 0, 0, 0, 0, 32+2*k, 33+2*k, 1, 32-2*k));
    vecs.push_back(mk(0, 1, 1, 10, 11, 0, 0, 0, 0, 0, 1, 32, 33, 0, 0));  // blocked dispatch
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 7, 5, 0, 0, 1, 32, 33, 0, 0));    // retire into empty
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 1, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 5, 1, 2));      // mid-run reset
    vecs.push_back(mk(0, 1, 1, 3, 4, 0, 0, 0, 0, 0, 0, 32, 33, 1, 32));
    vecs.push_back(mk(0, 1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 34, 35, 1, 30));
    vecs.push_back(mk(0, 1, 1, 7, 8, 0, 0, 0, 0, 0, 0, 36, 37, 1, 28));
    vecs.push_back(mk(0, 1, 1, 9, 10, 0, 0, 0, 1, 3, 0, 38, 39, 0, 26));  // rollback to ROB 3
    vecs.push_back(mk(0, 1, 1, 12, 13, 0, 0, 0, 0, 0, 0, 32, 33, 1, 32));
    vecs.push_back(mk(0, 1, 1, 14, 15, 0, 0, 0, 0, 0, 0, 34, 35, 1, 30));
    vecs.push_back(mk(0, 1, 1, 16, 17, 0, 0, 0, 0, 0, 0, 36, 37, 1, 28));
    vecs.push_back(mk(0, 1, 1, 18, 19, 0, 0, 0, 0, 0, 0, 38, 39, 1, 26));
    vecs.push_back(mk(0, 1, 0, 0, 0, 3, 20, 21, 0, 0, 0, 40, 41, 1, 24));
    vecs.push_back(mk(0, 1, 1, 20, 21, 3, 22, 23, 1, 16, 0, 40, 41, 0, 26)); // rollback+retire+dispatch
    for (int j = 0; j <= 10; j++)
      vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 36+2*j, 37+2*j, 1, 32-2*j));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 24, 0, 0, 0, 0, 58, 59, 1, 10));  // dispatch + retire 01
    vecs.push_back(mk(0, 0, 1, 0, 1, 3, 1, 2, 0, 0, 0, 60, 61, 1, 9));    // en=0 freeze
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 60, 61, 1, 9));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 62, 63, 1, 7));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 20, 21, 1, 5));    // head wrapped
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 20, 21, 1, 5));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 22, 23, 1, 3));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 22, 23, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24, 37, 0, 1));

    // Reset image.
    repeat (2) @(negedge clock);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("reset_T0", 32'(bus.T_idx[0]), 32);
    chk("reset_T1", 32'(bus.T_idx[1]), 33);
    chk("reset_valid", 32'(bus.FL_valid), 1);
    chk("reset_count", 32'(bus.free_count), 32);

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      #1;
      $display("vec %0d: T={%0d,%0d} valid=%0b count=%0d", i,
               bus.T_idx[1], bus.T_idx[0], bus.FL_valid, bus.free_count);
      chk($sformatf("v%0d_count", i), 32'(bus.free_count), 32'(vecs[i].e_cnt));
`ifdef FL_BYPASS_EN
      if (vecs[i].nb == 0) begin
`else
      begin
`endif
        chk($sformatf("v%0d_T0", i), 32'(bus.T_idx[0]), 32'(vecs[i].e_t0));
        chk($sformatf("v%0d_T1", i), 32'(bus.T_idx[1]), 32'(vecs[i].e_t1));
        chk($sformatf("v%0d_valid", i), 32'(bus.FL_valid), 32'(vecs[i].e_valid));
      end
    end

`ifdef FL_BYPASS_EN
    // Bypass from empty: retiring tags go straight to dispatch.
    @(negedge clock);
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      drive(mk(0, 1, 1, 2*k, 2*k+1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clock);
    drive(mk(0, 1, 1, 20, 21, 3, 8, 9, 0, 0, 0, 0, 0, 0, 0));
    #1;
    $display("bypass: T={%0d,%0d} valid=%0b count=%0d",
             bus.T_idx[1], bus.T_idx[0], bus.FL_valid, bus.free_count);
    chk("byp_T0", 32'(bus.T_idx[0]), 8);
    chk("byp_T1", 32'(bus.T_idx[1]), 9);
    chk("byp_valid", 32'(bus.FL_valid), 1);
    chk("byp_count", 32'(bus.free_count), 0);
    @(negedge clock);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("byp_after_count", 32'(bus.free_count), 0);
    chk("byp_after_valid", 32'(bus.FL_valid), 0);
`endif

    // Second reset returns to the full image.
    @(negedge clock);
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    $display("reset2: T={%0d,%0d} valid=%0b count=%0d",
             bus.T_idx[1], bus.T_idx[0], bus.FL_valid, bus.free_count);
    chk("reset2_T0", 32'(bus.T_idx[0]), 32);
    chk("reset2_T1", 32'(bus.T_idx[1]), 33);
    chk("reset2_count", 32'(bus.free_count), 32);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
